// File: rtl/enc8b10b_rx_decoder_mlane.sv
// Multi-lane 8b/10b receive decoder: running-disparity chain across lanes, code/disparity
// error flags, K/comma detect and a saturating error counter. One clock of latency.
module enc8b10b_rx_decoder_mlane #(
  parameter int LANES   = 2,
  parameter bit RD_INIT = 1'b0,
  parameter int CNT_W   = 16
) (
  input  logic                 BitCLK_10,
  input  logic                 Reset,
  input  logic [10*LANES-1:0]  RxParallel_10,
  input  logic                 RxValid_in,
  input  logic                 ErrCountClr,
  output logic [8*LANES-1:0]   RxParallel_8,
  output logic [LANES-1:0]     RxDataK,
  output logic [LANES-1:0]     CommaDet,
  output logic [LANES-1:0]     CodeErr,
  output logic [LANES-1:0]     DispErr,
  output logic                 RxValid,
  output logic                 RdOut,
  output logic [CNT_W-1:0]     ErrCount
);

  typedef struct packed {
    logic [7:0] data;
    logic       k;
    logic       comma;
    logic       cerr;
    logic       derr;
    logic       rd;
  } lane_res_t;

  function automatic lane_res_t decode_lane(input logic [9:0] sym, input logic rd_in);
    logic [5:0] b6;
    logic [3:0] b4, f4;
    int         ones6, ones4;
    logic       rd6, rd4, derr, cerr, v6, v4, k28, kx, a7, p7, use_a;
    logic [4:0] x;
    logic [2:0] y;
    lane_res_t  r;
    b6    = sym[9:4];
    b4    = sym[3:0];
    ones6 = $countones(b6);
    ones4 = $countones(b4);
    derr  = 1'b0;
    cerr  = 1'b0;
    rd6   = rd_in;
    if (ones6 == 3) begin
      if ((b6 == 6'b111000) && rd_in)  derr = 1'b1;
      if ((b6 == 6'b000111) && !rd_in) derr = 1'b1;
    end else if (ones6 == 4) begin
      derr = rd_in;
      rd6  = 1'b1;
    end else if (ones6 == 2) begin
      derr = !rd_in;
      rd6  = 1'b0;
    end else begin
      cerr = 1'b1;
      rd6  = (ones6 > 3);
    end
    rd4 = rd6;
    if (ones4 == 2) begin
      if ((b4 == 4'b1100) && rd6)  derr = 1'b1;
      if ((b4 == 4'b0011) && !rd6) derr = 1'b1;
    end else if (ones4 == 3) begin
      derr = derr | rd6;
      rd4  = 1'b1;
    end else if (ones4 == 1) begin
      derr = derr | !rd6;
      rd4  = 1'b0;
    end else begin
      cerr = 1'b1;
      rd4  = (ones4 > 2);
    end

    v6 = 1'b1;
    x  = 5'd0;
    case (b6)
      6'b100111, 6'b011000: x = 5'd0;
      6'b011101, 6'b100010: x = 5'd1;
      6'b101101, 6'b010010: x = 5'd2;
      6'b110001:            x = 5'd3;
      6'b110101, 6'b001010: x = 5'd4;
      6'b101001:            x = 5'd5;
      6'b011001:            x = 5'd6;
      6'b111000, 6'b000111: x = 5'd7;
      6'b111001, 6'b000110: x = 5'd8;
      6'b100101:            x = 5'd9;
      6'b010101:            x = 5'd10;
      6'b110100:            x = 5'd11;
      6'b001101:            x = 5'd12;
      6'b101100:            x = 5'd13;
      6'b011100:            x = 5'd14;
      6'b010111, 6'b101000: x = 5'd15;
      6'b011011, 6'b100100: x = 5'd16;
      6'b100011:            x = 5'd17;
      6'b010011:            x = 5'd18;
      6'b110010:            x = 5'd19;
      6'b001011:            x = 5'd20;
      6'b101010:            x = 5'd21;
      6'b011010:            x = 5'd22;
      6'b111010, 6'b000101: x = 5'd23;
      6'b110011, 6'b001100: x = 5'd24;
      6'b100110:            x = 5'd25;
      6'b010110:            x = 5'd26;
      6'b110110, 6'b001001: x = 5'd27;
      6'b001110, 6'b001111, 6'b110000: x = 5'd28;
      6'b101110, 6'b010001: x = 5'd29;
      6'b011110, 6'b100001: x = 5'd30;
      6'b101011, 6'b010100: x = 5'd31;
      default:              v6 = 1'b0;
    endcase

    // K28 in its RD+ form carries the complemented 4b group
    k28 = (b6 == 6'b001111) || (b6 == 6'b110000);
    f4  = (b6 == 6'b110000) ? ~b4 : b4;
    v4  = 1'b1;
    y   = 3'd0;
    case (f4)
      4'b1011, 4'b0100:                   y = 3'd0;
      4'b1001:                            y = 3'd1;
      4'b0101:                            y = 3'd2;
      4'b1100, 4'b0011:                   y = 3'd3;
      4'b1101, 4'b0010:                   y = 3'd4;
      4'b1010:                            y = 3'd5;
      4'b0110:                            y = 3'd6;
      4'b1110, 4'b0001, 4'b0111, 4'b1000: y = 3'd7;
      default:                            v4 = 1'b0;
    endcase
    a7 = (f4 == 4'b0111) || (f4 == 4'b1000);
    p7 = (f4 == 4'b1110) || (f4 == 4'b0001);
    kx = !k28 && a7 && ((x == 5'd23) || (x == 5'd27) || (x == 5'd29) || (x == 5'd30));
    use_a = (!rd6 && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))) ||
            ( rd6 && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14)));
    if (k28)     cerr = cerr | p7;
    else if (a7) cerr = cerr | !(use_a || kx);
    else if (p7) cerr = cerr | use_a;
    cerr = cerr | !v6 | !v4;

    r.data  = cerr ? 8'h00 : {y, x};
    r.k     = !cerr && (k28 || kx);
    r.comma = !cerr && k28 && ((y == 3'd1) || (y == 3'd5) || (y == 3'd7));
    r.cerr  = cerr;
    r.derr  = derr;
    r.rd    = rd4;
    return r;
  endfunction

  logic [8*LANES-1:0] data_q, data_d;
  logic [LANES-1:0]   k_q, k_d, comma_q, comma_d, cerr_q, cerr_d, derr_q, derr_d;
  logic               valid_q, rd_q, rd_d, rd_c;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W:0]     nerr, sum;
  lane_res_t          lane_r;

  always_comb begin
    rd_c    = rd_q;
    data_d  = '0;
    k_d     = '0;
    comma_d = '0;
    cerr_d  = '0;
    derr_d  = '0;
    nerr    = '0;
    lane_r  = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_r          = decode_lane(RxParallel_10[10*i +: 10], rd_c);
      rd_c            = lane_r.rd;
      data_d[8*i +: 8] = lane_r.data;
      k_d[i]          = lane_r.k;
      comma_d[i]      = lane_r.comma;
      cerr_d[i]       = lane_r.cerr;
      derr_d[i]       = lane_r.derr;
      nerr            = nerr + {{CNT_W{1'b0}}, (lane_r.cerr | lane_r.derr)};
    end
    rd_d = rd_c;
    sum  = {1'b0, cnt_q} + nerr;
    if (ErrCountClr)
      cnt_d = '0;
    else if (RxValid_in)
      cnt_d = (sum > {1'b0, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    else
      cnt_d = cnt_q;
  end

  always_ff @(posedge BitCLK_10) begin
    if (Reset) begin
      data_q  <= '0;
      k_q     <= '0;
      comma_q <= '0;
      cerr_q  <= '0;
      derr_q  <= '0;
      valid_q <= 1'b0;
      rd_q    <= RD_INIT;
      cnt_q   <= '0;
    end else begin
      valid_q <= RxValid_in;
      cnt_q   <= cnt_d;
      if (RxValid_in) begin
        data_q  <= data_d;
        k_q     <= k_d;
        comma_q <= comma_d;
        cerr_q  <= cerr_d;
        derr_q  <= derr_d;
        rd_q    <= rd_d;
      end
    end
  end

  assign RxParallel_8 = data_q;
  assign RxDataK      = k_q;
  assign CommaDet     = comma_q;
  assign CodeErr      = cerr_q;
  assign DispErr      = derr_q;
  assign RxValid      = valid_q;
  assign RdOut        = rd_q;
  assign ErrCount     = cnt_q;

endmodule

// File: tb/tb_enc8b10b_rx_decoder_mlane.sv
// Scoreboard bench for the two-lane 8b/10b decoder; a second instance with a 4-bit
// counter shares the stimulus so counter saturation can be observed.
module tb_enc8b10b_rx_decoder_mlane;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [19:0] din = '0;
  logic        vin = 1'b0;
  logic        clr = 1'b0;

  logic [15:0] q8;
  logic [1:0]  qk, qc, qce, qde;
  logic        qv, qrd;
  logic [15:0] qcnt;

  logic [15:0] q8_4;
  logic [1:0]  qk_4, qc_4, qce_4, qde_4;
  logic        qv_4, qrd_4;
  logic [3:0]  qcnt_4;

  always #5 clk = ~clk;

  enc8b10b_rx_decoder_mlane #(.LANES(2), .RD_INIT(1'b0), .CNT_W(16)) dut (
    .BitCLK_10(clk), .Reset(rst), .RxParallel_10(din), .RxValid_in(vin),
    .ErrCountClr(clr), .RxParallel_8(q8), .RxDataK(qk), .CommaDet(qc),
    .CodeErr(qce), .DispErr(qde), .RxValid(qv), .RdOut(qrd), .ErrCount(qcnt)
  );

  enc8b10b_rx_decoder_mlane #(.LANES(2), .RD_INIT(1'b0), .CNT_W(4)) dut4 (
    .BitCLK_10(clk), .Reset(rst), .RxParallel_10(din), .RxValid_in(vin),
    .ErrCountClr(clr), .RxParallel_8(q8_4), .RxDataK(qk_4), .CommaDet(qc_4),
    .CodeErr(qce_4), .DispErr(qde_4), .RxValid(qv_4), .RdOut(qrd_4), .ErrCount(qcnt_4)
  );

  typedef struct {
    logic [15:0] data;
    logic [1:0]  k, comma, cerr, derr;
    logic        rd;
    logic [15:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   m_cnt = 0;
  int   m_cnt4 = 0;

  task automatic send(input logic [9:0] l1, input logic [9:0] l0, input logic [15:0] data,
                      input logic [1:0] k, input logic [1:0] comma, input logic [1:0] cerr,
                      input logic [1:0] derr, input logic rd, input logic c);
    exp_t e;
    int   nerr;
    @(negedge clk);
    din = {l1, l0};
    vin = 1'b1;
    clr = c;
    nerr = int'(cerr[0] | derr[0]) + int'(cerr[1] | derr[1]);
    if (c) begin
      m_cnt  = 0;
      m_cnt4 = 0;
    end else begin
      m_cnt  = (m_cnt + nerr > 65535) ? 65535 : m_cnt + nerr;
      m_cnt4 = (m_cnt4 + nerr > 15) ? 15 : m_cnt4 + nerr;
    end
    e.data = data; e.k = k; e.comma = comma; e.cerr = cerr; e.derr = derr; e.rd = rd;
    e.cnt  = 16'(m_cnt);
    e.cnt4 = 4'(m_cnt4);
    sbq.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      vin = 1'b0;
      clr = 1'b0;
    end
  endtask

  // scoreboard: one expected entry per valid output word
  always @(negedge clk) begin
    if (qv) begin
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_valid got data=%h required no output", q8);
      end else begin
        mon_e = sbq.pop_front();
        if (q8 !== mon_e.data) begin bad++; $display("FAIL sb_data got=%h required=%h", q8, mon_e.data); end
        total++;
        if (qk !== mon_e.k) begin bad++; $display("FAIL sb_k got=%b required=%b", qk, mon_e.k); end
        total++;
        if (qc !== mon_e.comma) begin bad++; $display("FAIL sb_comma got=%b required=%b", qc, mon_e.comma); end
        total++;
        if (qce !== mon_e.cerr) begin bad++; $display("FAIL sb_codeerr got=%b required=%b", qce, mon_e.cerr); end
        total++;
        if (qde !== mon_e.derr) begin bad++; $display("FAIL sb_disperr got=%b required=%b", qde, mon_e.derr); end
        total++;
        if (qrd !== mon_e.rd) begin bad++; $display("FAIL sb_rdout got=%b required=%b", qrd, mon_e.rd); end
        total++;
        if (qcnt !== mon_e.cnt) begin bad++; $display("FAIL sb_errcount got=%0d required=%0d", qcnt, mon_e.cnt); end
        total++;
        if (qcnt_4 !== mon_e.cnt4) begin bad++; $display("FAIL sb_errcount4 got=%0d required=%0d", qcnt_4, mon_e.cnt4); end
      end
    end
  end

  task automatic check_reset_state(input string tag);
    total++;
    if ({q8, qk, qc, qce, qde, qv} !== 25'd0) begin
      bad++; $display("FAIL %s_outputs got=%h required=0", tag, {q8, qk, qc, qce, qde, qv});
    end
    total++;
    if (qrd !== 1'b0) begin bad++; $display("FAIL %s_rdout got=%b required=0", tag, qrd); end
    total++;
    if (qcnt !== 16'd0 || qcnt_4 !== 4'd0) begin
      bad++; $display("FAIL %s_errcount got=%0d/%0d required=0/0", tag, qcnt, qcnt_4);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    vin = 1'b1;
    din = {10'h305, 10'h0FA};
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;
    vin = 1'b0;
  endtask

  task automatic test_comma();
    send(10'h305, 10'h0FA, 16'hBCBC, 2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0);
    send(10'h307, 10'h0F9, 16'hFC3C, 2'b11, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0);
    send(10'h30B, 10'h057, 16'h1CF7, 2'b11, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
    send(10'h2AA, 10'h305, 16'hB5BC, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0);
    idle(2);
  endtask

  task automatic test_data_hold();
    send(10'h2AA, 10'h274, 16'hB500, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    vin = 1'b0;
    din = {10'h3FF, 10'h3FF};
    repeat (3) begin
      @(negedge clk);
      total++;
      if (qv !== 1'b0) begin bad++; $display("FAIL hold_valid got=%b required=0", qv); end
      total++;
      if (q8 !== 16'hB500 || qk !== 2'b00 || qce !== 2'b00) begin
        bad++; $display("FAIL hold_data got=%h k=%b cerr=%b required=b500/00/00", q8, qk, qce);
      end
      total++;
      if (qrd !== 1'b0 || qcnt !== 16'd0) begin
        bad++; $display("FAIL hold_rd_cnt got=%b/%0d required=0/0", qrd, qcnt);
      end
    end
    send(10'h348, 10'h237, 16'hEBF1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    idle(2);
  endtask

  task automatic test_disp_err();
    send(10'h2AA, 10'h305, 16'hB5BC, 2'b01, 2'b01, 2'b00, 2'b01, 1'b0, 1'b0);
    idle(2);
    total++;
    if (qcnt !== 16'd1) begin bad++; $display("FAIL disp_errcount got=%0d required=1", qcnt); end
  endtask

  task automatic test_code_err();
    send(10'h305, 10'h3FF, 16'hBC00, 2'b10, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0);
    send(10'h3FF, 10'h3FF, 16'h0000, 2'b00, 2'b00, 2'b11, 2'b00, 1'b1, 1'b0);
    send(10'h23E, 10'h305, 16'h00BC, 2'b01, 2'b01, 2'b10, 2'b00, 1'b1, 1'b0);
    send(10'h2AA, 10'h305, 16'hB5BC, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0);
    idle(2);
    total++;
    if (qcnt !== 16'd5) begin bad++; $display("FAIL code_errcount got=%0d required=5", qcnt); end
  endtask

  task automatic test_reset_midstream();
    send(10'h2AA, 10'h0FA, 16'hB5BC, 2'b01, 2'b01, 2'b00, 2'b00, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    vin = 1'b1;
    din = {10'h3FF, 10'h3FF};
    m_cnt  = 0;
    m_cnt4 = 0;
    @(negedge clk);
    check_reset_state("midreset");
    rst = 1'b0;
    vin = 1'b0;
    send(10'h2AA, 10'h0FA, 16'hB5BC, 2'b01, 2'b01, 2'b00, 2'b00, 1'b1, 1'b0);
    idle(2);
  endtask

  task automatic test_saturate();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_cnt  = 0;
    m_cnt4 = 0;
    for (int i = 0; i < 7; i++)
      send(10'h3FF, 10'h3FF, 16'h0000, 2'b00, 2'b00, 2'b11, 2'b00, 1'b1, 1'b0);
    send(10'h305, 10'h3FF, 16'hBC00, 2'b10, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0);
    send(10'h3FF, 10'h3FF, 16'h0000, 2'b00, 2'b00, 2'b11, 2'b00, 1'b1, 1'b0);
    idle(2);
    total++;
    if (qcnt_4 !== 4'd15) begin bad++; $display("FAIL sat_errcount4 got=%0d required=15", qcnt_4); end
    total++;
    if (qcnt !== 16'd17) begin bad++; $display("FAIL sat_errcount got=%0d required=17", qcnt); end
  endtask

  task automatic test_clear();
    send(10'h3FF, 10'h3FF, 16'h0000, 2'b00, 2'b00, 2'b11, 2'b00, 1'b1, 1'b1);
    idle(1);
    total++;
    if (qcnt !== 16'd0 || qcnt_4 !== 4'd0) begin
      bad++; $display("FAIL clr_errcount got=%0d/%0d required=0/0", qcnt, qcnt_4);
    end
    idle(1);
  endtask

  initial begin
    test_reset();
    test_comma();
    test_data_hold();
    test_disp_err();
    test_code_err();
    test_reset_midstream();
    test_saturate();
    test_clear();
    idle(2);
    total++;
    if (sbq.size() != 0) begin bad++; $display("FAIL sb_drain got=%0d pending required=0", sbq.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/enc8b10b_rx_decoder_mlane.md
Name: enc8b10b_rx_decoder_mlane

Overview:
Multi-lane, parametrised 8b/10b receive decoder with running-disparity tracking, code/disparity error detection, K-character and comma flagging, and a saturating error counter. It sits after the deserialiser/word aligner in the RX path. It accepts LANES 10-bit symbols per clock and emits LANES decoded bytes one cycle later. It supersedes the single-lane table decoder by adding a valid qualifier, control-character decode and line-integrity checks.

Parameters:
LANES, 2, symbols decoded per clock; lane 0 is earliest in time.
RD_INIT, 0, running disparity after reset (0 = RD-, 1 = RD+).
CNT_W, 16, error counter width.

Ports:
BitCLK_10  in  1  word clock; all logic on rising edge.
Reset  in  1  synchronous, active-high reset.
RxParallel_10  in  10*LANES  symbols; lane n at [10n+9:10n]; within a lane [9:4]=abcdei (a at bit 9), [3:0]=fghj (f at bit 3).
RxValid_in  in  1  input word valid.
ErrCountClr  in  1  synchronous clear of ErrCount.
RxParallel_8  out  8*LANES  decoded bytes; lane n at [8n+7:8n] = {HGF,EDCBA}.
RxDataK  out  LANES  lane holds a valid K character.
CommaDet  out  LANES  lane holds K28.1, K28.5 or K28.7.
CodeErr  out  LANES  symbol not in the 8b/10b code table.
DispErr  out  LANES  running-disparity violation.
RxValid  out  1  outputs valid.
RdOut  out  1  registered running disparity after the last lane.
ErrCount  out  CNT_W  saturating count of errored symbols.

Behaviour:
- Reset high at a clock edge: all outputs 0, except RdOut = RD_INIT. The internal RD register is loaded with RD_INIT. Reset mid-stream discards in-flight data. The first valid word after reset is decoded against RD_INIT.
- Latency: exactly 1 clock. Inputs are sampled at edge k with RxValid_in=1; results are registered at edge k. RxValid is high for that single cycle.
- RxValid_in=0: RxValid=0 next cycle. Data, flag and RdOut registers hold their previous values. RD and ErrCount are unchanged.
- RD chaining is combinational across lanes within one word: lane 0 uses the RD register, lane n uses the RD after lane n-1, and the RD register/RdOut take the RD after lane LANES-1.
- Sub-block disparity (6b, then 4b):
  - More ones than zeros (4 of 6, or 3 of 4): legal only at RD-, otherwise DispErr. RD becomes +.
  - Fewer ones than zeros: legal only at RD+, otherwise DispErr. RD becomes -.
  - Balanced: RD unchanged. Exceptions: 6b 111000 and 4b 1100 require RD-; 6b 000111 and 4b 0011 require RD+. A violation flags DispErr.
  - Ones count outside 2..4 (6b) or 1..3 (4b): CodeErr. RD becomes + if ones exceed half, else -.
- Code table: IEEE 802.3 Clause 36 data and control code groups.
  - D.x.A7 (4b 0111/1000) is valid only for x=17,18,20 at RD- and x=11,13,14 at RD+. Primary .7 is used otherwise; a mismatch flags CodeErr.
  - K valid set: K28.0–K28.7, K23.7, K27.7, K29.7, K30.7.
  - Any 10-bit group not in the tables flags CodeErr.
- CodeErr lane: byte forced to 8'h00; RxDataK=0; CommaDet=0; DispErr may also be set.
- DispErr without CodeErr: byte and K flags are still decoded normally.
- ErrCount update:
  - Adds the number of lanes with (CodeErr|DispErr) on each valid word.
  - Saturates at all-ones; no wrap.
  - ErrCountClr=1 forces 0 that cycle, taking priority over the same-cycle increment; errors in that word are not counted.
  - Reset also clears the counter.

Test Plan:
- LANES=2, RD_INIT=0, reset, then RxValid_in=1 with {0x305,0x0FA} -> next cycle RxParallel_8=0xBCBC, RxDataK=2'b11, CommaDet=2'b11, CodeErr=0, DispErr=0, RdOut=0, ErrCount=0.
- From RD-, lane0=0x274 (D0.0), lane1=0x2AA (D21.5) -> bytes 0xB5,0x00 (RxParallel_8=0xB500), K=0, RdOut=0; hold RxValid_in=0 for 3 cycles -> RxValid=0, outputs and RdOut unchanged.
- From RD-, lane0=0x305 (K28.5 RD+ form) -> DispErr[0]=1, byte 0xBC, RxDataK[0]=1, ErrCount increments by 1.
- Lane0=0x3FF -> CodeErr[0]=1, byte 0x00, RxDataK[0]=0, RD after lane0 = +; with both lanes 0x3FF -> ErrCount +2.
- CNT_W=4: inject errors until ErrCount=15, inject more -> stays 15. Assert ErrCountClr together with an errored word -> ErrCount=0.
- Reset asserted mid-stream while RD=+ -> next cycle all outputs 0, RdOut=RD_INIT. The first word after reset, 0x0FA, decodes as 0xBC with no DispErr.
